// File: rtl/alu_pipe.sv
// Pipelined ALU with a fixed-latency datapath feeding a credit-managed output buffer.
// Results leave in acceptance order. Each result carries its tag and a reserved-opcode flag.
module alu_pipe #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 4,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           opcode,
  input  logic [ADDR_W-1:0]    addr_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [ADDR_W-1:0]    addr_out,
  output logic                 err,
  output logic [15:0]          op_count
);

  localparam int RW    = 2 * WIDTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

  // Returns {err, result}; operands are zero-extended before the operation.
  function automatic logic [RW:0] alu_eval(input logic [2:0] op,
                                           input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y);
    logic [RW-1:0] xz;
    logic [RW-1:0] yz;
    logic [RW-1:0] r;
    logic          e;
    xz = RW'(x);
    yz = RW'(y);
    r  = '0;
    e  = 1'b0;
    case (op)
      3'd0:    r = xz + yz;
      3'd1:    r = xz - yz;
      3'd2:    r = xz & yz;
      3'd3:    r = xz | yz;
      3'd4:    r = xz ^ yz;
      3'd5:    r = xz * yz;
      3'd6:    r = xz;
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [RW:0]          alu_out;

  logic [LATENCY-1:0]   vld_q;
  logic [RW-1:0]        res_q  [LATENCY];
  logic [ADDR_W-1:0]    tag_q  [LATENCY];
  logic [LATENCY-1:0]   perr_q;

  logic [RW-1:0]        buf_res_q [DEPTH];
  logic [ADDR_W-1:0]    buf_tag_q [DEPTH];
  logic [DEPTH-1:0]     buf_err_q;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     used_q, used_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [15:0]          op_count_q, op_count_d;

  assign alu_out = alu_eval(opcode, a, b);

  // used_q counts buffered plus in-flight entries, so a free credit always implies buffer space.
  always_comb begin
    in_ready   = (used_q < CNT_MAX);
    accept     = in_valid & in_ready;
    push       = vld_q[LATENCY-1];
    out_valid  = (cnt_q != '0);
    pop        = out_valid & out_ready;
    cnt_d      = cnt_q;
    used_d     = used_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({accept, pop})
      2'b10:   used_d = used_q + CNT_W'(1);
      2'b01:   used_d = used_q - CNT_W'(1);
      default: used_d = used_q;
    endcase
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    op_count_d = pop  ? sat_inc16(op_count_q) : op_count_q;
  end

  // Stage p0..p(LATENCY-1): valid chain under reset, data chain free-running
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      res_q[0]  <= alu_out[RW-1:0];
      tag_q[0]  <= addr_in;
      perr_q[0] <= alu_out[RW];
    end
    for (int i = 1; i < LATENCY; i++) begin
      res_q[i]  <= res_q[i-1];
      tag_q[i]  <= tag_q[i-1];
      perr_q[i] <= perr_q[i-1];
    end
  end

  // Output buffer: circular storage written from the last pipeline stage
  always_ff @(posedge clk) begin
    if (push) begin
      buf_res_q[wr_ptr_q] <= res_q[LATENCY-1];
      buf_tag_q[wr_ptr_q] <= tag_q[LATENCY-1];
      buf_err_q[wr_ptr_q] <= perr_q[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      used_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      op_count_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      used_q     <= used_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      op_count_q <= op_count_d;
    end
  end

  // Buffer contents are not reset, so the head is masked to zero while empty.
  assign result   = out_valid ? buf_res_q[rd_ptr_q] : '0;
  assign addr_out = out_valid ? buf_tag_q[rd_ptr_q] : '0;
  assign err      = out_valid ? buf_err_q[rd_ptr_q] : 1'b0;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and seeded-random bench for alu_pipe at WIDTH=8, ADDR_W=4, LATENCY=2, DEPTH=4.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  opcode;
  logic [3:0]  addr_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  addr_out;
  logic        err;
  logic [15:0] op_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .ADDR_W(4), .LATENCY(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .addr_out(addr_out), .err(err), .op_count(op_count)
  );

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timed out");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    reset    = 1'b0;
  endtask

  function automatic logic [16:0] ref_alu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] xw;
    logic [15:0] yw;
    xw = {8'h00, x};
    yw = {8'h00, y};
    case (op)
      3'd0:    return {1'b0, xw + yw};
      3'd1:    return {1'b0, xw - yw};
      3'd2:    return {1'b0, xw & yw};
      3'd3:    return {1'b0, xw | yw};
      3'd4:    return {1'b0, xw ^ yw};
      3'd5:    return {1'b0, xw * yw};
      3'd6:    return {1'b0, xw};
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  // One isolated operation: accept, confirm two-edge latency and the head contents, then pop.
  task automatic single(input string tag, input logic [2:0] op, input logic [7:0] x,
                        input logic [7:0] y, input logic [3:0] t,
                        input logic [31:0] exp_res, input logic [31:0] exp_err);
    int lat;
    out_ready = 1'b1;
    opcode    = op;
    a         = x;
    b         = y;
    addr_in   = t;
    in_valid  = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 2);
    chk({tag, "_res"}, 32'(result), exp_res);
    chk({tag, "_tag"}, 32'(addr_out), 32'(t));
    chk({tag, "_err"}, 32'(err), exp_err);
    step();
    chk({tag, "_empty"}, 32'(out_valid), 0);
  endtask

  initial begin
    int   nacc;
    int   nout;
    int   nin;
    int   dropped;
    int   stale;
    int   npop;
    bit   acc;
    bit   ordy;
    bit   prev_stall;
    logic [15:0] held_res;
    logic [3:0]  held_tag;
    logic        held_err;
    logic [16:0] r;
    exp_t e;
    exp_t q[$];

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = '0;
    addr_in   = '0;
    do_reset();

    chk("rst_in_ready",  32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result",    32'(result), 0);
    chk("rst_addr_out",  32'(addr_out), 0);
    chk("rst_err",       32'(err), 0);
    chk("rst_op_count",  32'(op_count), 0);

    single("add_carry", 3'd0, 8'hFF, 8'h01, 4'd3, 'h0100, 0);
    single("sub_wrap",  3'd1, 8'h01, 8'h02, 4'd5, 'hFFFF, 0);
    single("mul_full",  3'd5, 8'hFF, 8'hFF, 4'd6, 'hFE01, 0);
    single("op7",       3'd7, 8'h12, 8'h34, 4'd7, 'h0000, 1);
    single("and",       3'd2, 8'hF0, 8'h3C, 4'd8, 'h0030, 0);
    single("or",        3'd3, 8'hF0, 8'h3C, 4'd9, 'h00FC, 0);
    single("xor",       3'd4, 8'hF0, 8'h3C, 4'd10, 'h00CC, 0);
    single("passa",     3'd6, 8'hA5, 8'h5A, 4'd11, 'h00A5, 0);
    chk("single_op_count", 32'(op_count), 8);

    // Fill with the consumer stalled: exactly DEPTH accepts, then the head must hold.
    out_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      opcode   = 3'd0;
      a        = 8'(nacc);
      b        = 8'd1;
      addr_in  = 4'(nacc);
      acc      = in_ready;
      step();
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    chk("fill_accepts",   32'(nacc), 4);
    chk("fill_in_ready",  32'(in_ready), 0);
    chk("fill_out_valid", 32'(out_valid), 1);
    chk("fill_hold_tag",  32'(addr_out), 0);
    chk("fill_hold_res",  32'(result), 1);
    out_ready = 1'b1;
    #1;
    chk("pop_no_comb_rdy", 32'(in_ready), 0);
    nout = 0;
    for (int c = 0; c < 20 && nout < 4; c++) begin
      if (out_valid) begin
        chk("drain_tag", 32'(addr_out), 32'(nout));
        chk("drain_res", 32'(result), 32'(nout + 1));
        nout++;
      end
      step();
    end
    chk("drain_count",    32'(nout), 4);
    chk("drain_op_count", 32'(op_count), 12);

    // Sustained streaming with the consumer always ready.
    do_reset();
    out_ready = 1'b1;
    nin = 0;
    nout = 0;
    dropped = 0;
    for (int c = 0; c < 60 && nout < 20; c++) begin
      if (out_valid) begin
        chk("stream_tag", 32'(addr_out), 32'(nout % 16));
        chk("stream_res", 32'(result), 32'((nout + 1) * (nout + 3)));
        nout++;
      end
      acc = 1'b0;
      if (nin < 20) begin
        if (!in_ready) dropped++;
        in_valid = 1'b1;
        opcode   = 3'd5;
        a        = 8'(nin + 1);
        b        = 8'(nin + 3);
        addr_in  = 4'(nin);
        acc      = in_ready;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (acc) nin++;
    end
    in_valid = 1'b0;
    chk("stream_dropped",  32'(dropped), 0);
    chk("stream_accepts",  32'(nin), 20);
    chk("stream_outputs",  32'(nout), 20);
    chk("stream_op_count", 32'(op_count), 20);

    // Reset with one entry buffered and two still in the pipeline.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      opcode   = 3'd0;
      a        = 8'(i);
      b        = 8'd0;
      addr_in  = 4'(i + 1);
      step();
    end
    chk("prerst_out_valid", 32'(out_valid), 1);
    reset    = 1'b1;
    in_valid = 1'b1;
    a        = 8'h77;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready",  32'(in_ready), 1);
    chk("midrst_op_count",  32'(op_count), 0);
    chk("midrst_result",    32'(result), 0);
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid) stale++;
    end
    chk("midrst_stale", 32'(stale), 0);

    // Seeded random stream against the reference model, with random stalls.
    do_reset();
    nacc = 0;
    npop = 0;
    prev_stall = 1'b0;
    held_res = '0;
    held_tag = '0;
    held_err = 1'b0;
    for (int c = 0; c < 600 && (nacc < 60 || q.size() > 0); c++) begin
      ordy = ($urandom_range(0, 9) < 6);
      out_ready = ordy;
      if (prev_stall) begin
        chk("rnd_stable_res", 32'(result), 32'(held_res));
        chk("rnd_stable_tag", 32'(addr_out), 32'(held_tag));
        chk("rnd_stable_err", 32'(err), 32'(held_err));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("rnd_spurious", 32'(out_valid), 0);
        end else begin
          chk("rnd_res", 32'(result), 32'(q[0].res));
          chk("rnd_tag", 32'(addr_out), 32'(q[0].tag));
          chk("rnd_err", 32'(err), 32'(q[0].err));
          if (ordy) begin
            void'(q.pop_front());
            npop++;
          end
        end
        prev_stall = !ordy;
        held_res = result;
        held_tag = addr_out;
        held_err = err;
      end else begin
        prev_stall = 1'b0;
      end
      if (nacc < 60 && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        opcode   = 3'($urandom_range(0, 7));
        a        = 8'($urandom);
        b        = 8'($urandom);
        addr_in  = 4'(nacc);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        r = ref_alu(opcode, a, b);
        e.res = r[15:0];
        e.tag = addr_in;
        e.err = r[16];
        q.push_back(e);
        nacc++;
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rnd_drained",  32'(q.size()), 0);
    chk("rnd_pops",     32'(npop), 60);
    chk("rnd_op_count", 32'(op_count), 32'(npop));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
